frame_len_fifo: RTL and testbench
=================================

Name: frame_len_fifo

Overview:
- Sits directly downstream of the frame stage and consumes its cleaned valid_out/sop_out/eop_out stream.
- Measures the length of each frame in valid beats.
- Queues one length record per completed frame in a small first-word-fall-through FIFO, which a valid/ready consumer drains.
- Keeps sticky overflow, drop and protocol-error statistics for the debug/status path.

Parameters:
- LEN_W, 12, width of the length field; lengths saturate at 2**LEN_W-1.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of the drop and protocol-error counters; they saturate at all-ones.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- valid_in  in  1  beat qualifier from the frame stage.
- sop_in  in  1  start of frame; meaningful only when valid_in=1.
- eop_in  in  1  end of frame; meaningful only when valid_in=1.
- len_valid  out  1  FIFO head record available.
- len_ready  in  1  consumer accepts the head record when len_valid=1.
- len_data  out  LEN_W  frame length in beats at the FIFO head.
- len_trunc  out  1  head frame exceeded 2**LEN_W-1 beats.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a record was dropped because the FIFO was full.
- drop_cnt  out  CNT_W  number of dropped records, saturating.
- proto_err_cnt  out  CNT_W  number of framing violations seen, saturating.
- clr_stats  in  1  synchronous clear of overflow, drop_cnt and proto_err_cnt.

Behaviour:
- Reset values: state=IDLE, beat counter=0, FIFO empty, len_valid=0, len_data=0, len_trunc=0, fifo_level=0, overflow=0, drop_cnt=0, proto_err_cnt=0.
- Only beats with valid_in=1 are seen. sop_in and eop_in are ignored when valid_in=0.
- FSM has two states, IDLE and IN_FRAME.
  - IDLE, valid&sop&eop: single-beat frame; push length 1; stay in IDLE.
  - IDLE, valid&sop&!eop: counter=1; go to IN_FRAME.
  - IDLE, valid&!sop&eop: orphan EOP; proto_err_cnt+1; no push.
  - IDLE, valid with neither sop nor eop: ignored.
  - IN_FRAME, valid&!sop&!eop: counter+1, saturating at all-ones; trunc flag set on the saturating increment.
  - IN_FRAME, valid&!sop&eop: push counter+1 (saturated); go to IDLE.
  - IN_FRAME, valid&sop: the open frame is abandoned with no push, and proto_err_cnt+1. If eop is also set, push length 1 and go to IDLE. Otherwise counter=1 and stay in IN_FRAME.
- Trunc flag: cleared at every SOP, carried into the record as len_trunc.
- Push timing: the record is written on the edge that samples the EOP beat. len_valid rises the following cycle when the FIFO was empty (latency 1).
- FIFO is first-word fall-through: len_valid = (fifo_level != 0), and len_data/len_trunc show the head entry. A pop occurs when len_valid & len_ready.
  - len_data/len_trunc read 0 when the FIFO is empty.
- Full and simultaneous events:
  - A push is accepted if fifo_level<DEPTH, or if a pop happens in the same cycle.
  - Push without pop into a full FIFO: record dropped, overflow<=1, drop_cnt+1.
  - Simultaneous push and pop: fifo_level unchanged.
- Pointers wrap modulo DEPTH. fifo_level never exceeds DEPTH and never underflows.
  - len_ready while empty has no effect.
- Counters saturate at 2**CNT_W-1.
- clr_stats:
  - Clears overflow, drop_cnt and proto_err_cnt. It does not touch the FIFO or the FSM.
  - If clr_stats coincides with a drop or protocol error, the clear wins and the counter reads 0.
- Reset mid-frame: the partial frame and FIFO contents are discarded. After reset, an EOP arriving before any SOP counts as a protocol error.

Test Plan:
- Single-beat frames: three consecutive valid&sop&eop beats with len_ready=1 -> three records, len_data=1 each; len_valid is first seen one cycle after the first beat; fifo_level never exceeds 1.
- Gapped frame: SOP, 3 middle beats interleaved with valid_in=0 cycles, then EOP -> one record, len_data=5, len_trunc=0.
- Full FIFO with DEPTH=8, len_ready=0: 9 frames -> fifo_level=8, overflow=1, drop_cnt=1. Then raise len_ready together with a 10th EOP -> push accepted, fifo_level stays 8.
- Protocol errors: orphan EOP in IDLE; later a second SOP inside an open frame -> proto_err_cnt=2. Only the restarted frame produces a record, with length counted from the second SOP.
- Truncation with LEN_W=4: a 20-beat frame -> len_data=15, len_trunc=1. The next frame of 2 beats -> len_data=2, len_trunc=0.
- Reset and clear: assert rst mid-frame with 3 records queued -> all outputs 0 immediately. clr_stats pulsed together with an orphan EOP -> proto_err_cnt=0.

Source files
------------

// File: rtl/frame_len_fifo.sv
// Frame length recorder: counts valid beats per SOP..EOP frame and queues one
// {trunc, length} record per frame in a first-word-fall-through FIFO.
module frame_len_fifo #(
  parameter int LEN_W = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic                     sop_in,
  input  logic                     eop_in,
  output logic                     len_valid,
  input  logic                     len_ready,
  output logic [LEN_W-1:0]         len_data,
  output logic                     len_trunc,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         proto_err_cnt,
  input  logic                     clr_stats
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             trunc_reg, trunc_next;

  logic             push;
  logic [LEN_W-1:0] push_len;
  logic             push_trunc;
  logic             proto_err;

  logic             cnt_sat;
  logic [LEN_W-1:0] cnt_inc;

  logic [LEN_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [LEN_W:0]   head;
  logic             pop;
  logic             wr_en;
  logic             drop;

  // Saturating beat count; hitting the ceiling marks the frame as truncated.
  assign cnt_sat = (cnt_reg == LEN_MAX);
  assign cnt_inc = cnt_sat ? cnt_reg : cnt_reg + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      trunc_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      trunc_reg <= trunc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    trunc_next = trunc_reg;
    push       = 1'b0;
    push_len   = '0;
    push_trunc = 1'b0;
    proto_err  = 1'b0;
    if (valid_in) begin
      case (state_reg)
        IDLE: begin
          if (sop_in && eop_in) begin
            push       = 1'b1;
            push_len   = LEN_W'(1);
            trunc_next = 1'b0;
          end else if (sop_in) begin
            cnt_next   = LEN_W'(1);
            trunc_next = 1'b0;
            state_next = IN_FRAME;
          end else if (eop_in) begin
            proto_err = 1'b1;
          end
        end
        IN_FRAME: begin
          if (sop_in) begin
            // A new SOP abandons the open frame and restarts counting.
            proto_err  = 1'b1;
            trunc_next = 1'b0;
            if (eop_in) begin
              push       = 1'b1;
              push_len   = LEN_W'(1);
              state_next = IDLE;
            end else begin
              cnt_next = LEN_W'(1);
            end
          end else if (eop_in) begin
            push       = 1'b1;
            push_len   = cnt_inc;
            push_trunc = trunc_reg | cnt_sat;
            state_next = IDLE;
          end else begin
            cnt_next   = cnt_inc;
            trunc_next = trunc_reg | cnt_sat;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign len_valid  = (level_reg != '0);
  assign pop        = len_valid & len_ready;
  assign wr_en      = push & ((level_reg < LVL_W'(DEPTH)) | pop);
  assign drop       = push & ~wr_en;
  assign fifo_level = level_reg;

  always_comb begin
    level_next = level_reg;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

  // Storage holds no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= {push_trunc, push_len};
  end

  assign head      = mem[rd_ptr_reg];
  assign len_data  = len_valid ? head[LEN_W-1:0] : '0;
  assign len_trunc = len_valid ? head[LEN_W] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      drop_cnt      <= '0;
      proto_err_cnt <= '0;
    end else if (clr_stats) begin
      overflow      <= 1'b0;
      drop_cnt      <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != CNT_MAX)
          drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (proto_err && proto_err_cnt != CNT_MAX)
        proto_err_cnt <= proto_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_len_fifo.sv
// Randomized and directed bench for frame_len_fifo with a frame-level model
// and a queue scoreboard drained by an independent output monitor.
module tb_frame_len_fifo;
  localparam int LEN_W   = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 3;
  localparam int LEN_MAX = 15;
  localparam int CNT_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0, sop_in = 1'b0, eop_in = 1'b0;
  logic len_ready = 1'b0, clr_stats = 1'b0;
  logic len_valid, len_trunc, overflow;
  logic [LEN_W-1:0] len_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0] drop_cnt, proto_err_cnt;

  frame_len_fifo #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sop_in(sop_in), .eop_in(eop_in),
    .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
    .len_trunc(len_trunc), .fifo_level(fifo_level), .overflow(overflow),
    .drop_cnt(drop_cnt), .proto_err_cnt(proto_err_cnt), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct {int len; bit trunc;} rec_t;
  rec_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Frame-level reference state: unbounded beat count, occupancy, statistics.
  int m_level = 0, m_ovf = 0, m_drop = 0, m_proto = 0, m_count = 0;
  bit m_in_frame = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_level = 0; m_ovf = 0; m_drop = 0; m_proto = 0; m_count = 0;
    m_in_frame = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Drive one cycle; predict its outcome from the framing rules.
  task automatic step(input bit v, input bit s, input bit e, input bit r, input bit c = 0);
    bit push, perr, pop, drp;
    int nxt;
    rec_t rec;
    valid_in = v; sop_in = s; eop_in = e; len_ready = r; clr_stats = c;
    push = 0; perr = 0; drp = 0;
    if (v) begin
      if (s) begin
        if (m_in_frame) perr = 1;
        m_in_frame = 1;
        m_count = 1;
        if (e) begin push = 1; m_in_frame = 0; end
      end else if (e) begin
        if (m_in_frame) begin m_count++; push = 1; m_in_frame = 0; end
        else perr = 1;
      end else if (m_in_frame) begin
        m_count++;
      end
    end
    pop = (m_level > 0) && r;
    nxt = m_level;
    if (push) begin
      if (m_level < DEPTH || pop) begin
        rec.len = (m_count > LEN_MAX) ? LEN_MAX : m_count;
        rec.trunc = (m_count > LEN_MAX);
        sb_q.push_back(rec);
        nxt++;
      end else begin
        drp = 1;
      end
    end
    if (pop) nxt--;
    @(posedge clk);
    m_level = nxt;
    if (c) begin
      m_ovf = 0; m_drop = 0; m_proto = 0;
    end else begin
      if (drp) begin m_ovf = 1; m_drop = sat_inc(m_drop); end
      if (perr) m_proto = sat_inc(m_proto);
    end
    #1;
    $display("step v=%0b s=%0b e=%0b rdy=%0b clr=%0b -> level=%0d vld=%0b len=%0d tr=%0b drop=%0d perr=%0d",
             v, s, e, r, c, fifo_level, len_valid, len_data, len_trunc, drop_cnt, proto_err_cnt);
  endtask

  // Output monitor: compares the DUT against the model and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("fifo_level", int'(fifo_level), m_level);
      chk("len_valid", int'(len_valid), int'(m_level != 0));
      chk("overflow", int'(overflow), m_ovf);
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("proto_err_cnt", int'(proto_err_cnt), m_proto);
      if (!len_valid) begin
        chk("len_data_empty", int'(len_data), 0);
        chk("len_trunc_empty", int'(len_trunc), 0);
      end else if (len_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_without_record", 1, 0);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          chk("len_data", int'(len_data), r.len);
          chk("len_trunc", int'(len_trunc), int'(r.trunc));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_len_valid"}, int'(len_valid), 0);
    chk({tag, "_len_data"}, int'(len_data), 0);
    chk({tag, "_len_trunc"}, int'(len_trunc), 0);
    chk({tag, "_fifo_level"}, int'(fifo_level), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    chk({tag, "_proto_err_cnt"}, int'(proto_err_cnt), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    int rdy_pct;
    // Reset state
    rst = 1'b1;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat frames back to back with the consumer ready
    step(1, 1, 1, 1);
    chk("first_valid_latency", int'(len_valid), 1);
    chk("single_level1", int'(fifo_level), 1);
    step(1, 1, 1, 1);
    chk("single_level2", int'(fifo_level), 1);
    step(1, 1, 1, 1);
    chk("single_level3", int'(fifo_level), 1);
    drain();

    // Gapped 5-beat frame
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("gapped_len", int'(len_data), 5);
    chk("gapped_trunc", int'(len_trunc), 0);
    drain();

    // Fill to DEPTH, then one more, then push with simultaneous pop
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 1, 0);
    chk("full_level", int'(fifo_level), DEPTH);
    chk("full_overflow", int'(overflow), 1);
    chk("full_drop", int'(drop_cnt), 1);
    step(1, 1, 1, 1);
    chk("full_push_pop_level", int'(fifo_level), DEPTH);
    chk("full_drop_after", int'(drop_cnt), 1);
    drain();

    // Orphan EOP, then a restarted frame
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("proto_cnt", int'(proto_err_cnt), 2);
    chk("proto_restart_len", int'(len_data), 4);
    chk("proto_one_record", int'(fifo_level), 1);
    drain();

    // Truncation: 20 beats then 2 beats
    step(1, 1, 0, 0);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    chk("trunc_len", int'(len_data), 15);
    chk("trunc_flag", int'(len_trunc), 1);
    step(0, 0, 0, 1);
    chk("after_trunc_len", int'(len_data), 2);
    chk("after_trunc_flag", int'(len_trunc), 0);
    drain();

    // Exactly 15 and 16 beats straddle the saturation point
    step(1, 1, 0, 0);
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("len15", int'(len_data), 15);
    chk("len15_trunc", int'(len_trunc), 0);
    drain();
    step(1, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("len16_trunc", int'(len_trunc), 1);
    drain();

    // Saturating statistics
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
    chk("proto_sat", int'(proto_err_cnt), CNT_MAX);
    for (int i = 0; i < DEPTH + 10; i++) step(1, 1, 1, 0);
    chk("drop_sat", int'(drop_cnt), CNT_MAX);
    step(0, 0, 0, 0, 1);
    chk("clr_drop", int'(drop_cnt), 0);
    chk("clr_keeps_fifo", int'(fifo_level), DEPTH);
    drain();

    // Reset mid-frame with three records queued
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    valid_in = 0; sop_in = 0; eop_in = 0; len_ready = 0; clr_stats = 0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 0, 1, 0);
    chk("post_reset_orphan", int'(proto_err_cnt), 1);
    chk("post_reset_no_record", int'(fifo_level), 0);
    step(1, 0, 1, 0, 1);
    chk("clr_wins", int'(proto_err_cnt), 0);

    // Randomized traffic with varying consumer pressure
    for (int ph = 0; ph < 6; ph++) begin
      rdy_pct = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 30 : 5);
      for (int i = 0; i < 400; i++) begin
        step(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
             ($urandom % 100) < rdy_pct, ($urandom % 150) == 0);
      end
    end
    drain();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
